// File: rtl/sequence_generator.sv
// sequence_generator: serial LSB-first pattern transmitter with repeat count and inter-repetition gap
module sequence_generator #(
  parameter int PAT_W   = 4,
  parameter int CNT_W   = 8,
  parameter int GAP_CYC = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  output logic             busy,
  output logic             data_out,
  output logic             data_valid,
  output logic             frame_start,
  output logic             done
);
  localparam int BW = $clog2(PAT_W);
  localparam int GW = GAP_CYC > 1 ? $clog2(GAP_CYC) : 1;
  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;
  state_t state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d, sh_q, sh_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [GW-1:0] gap_q, gap_d;
  logic busy_q, busy_d, data_q, data_d, valid_q, valid_d, fs_q, fs_d, done_q, done_d;
  logic last;
  assign last = bit_q == BW'(PAT_W - 1);
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    rep_d   = rep_q;
    gap_d   = gap_q;
    busy_d  = 1'b0;
    data_d  = 1'b0;
    valid_d = 1'b0;
    fs_d    = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // busy_q still high means the done cycle is on the outputs: start is ignored there
        if (start && !busy_q) begin
          pat_d   = pattern;
          sh_d    = pattern;
          rep_d   = repeat_cnt == '0 ? CNT_W'(1) : repeat_cnt;
          bit_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        busy_d  = 1'b1;
        valid_d = 1'b1;
        data_d  = sh_q[0];
        fs_d    = bit_q == '0;
        bit_d   = last ? '0 : bit_q + 1'b1;
        sh_d    = last ? pat_q : sh_q >> 1;
        rep_d   = last && rep_q != CNT_W'(1) ? rep_q - 1'b1 : rep_q;
        gap_d   = '0;
        state_d = !last ? SEND : rep_q == CNT_W'(1) ? DONE : GAP_CYC > 0 ? GAP : SEND;
      end
      GAP: begin
        busy_d  = 1'b1;
        gap_d   = gap_q + 1'b1;
        state_d = gap_q == GW'(GAP_CYC - 1) ? SEND : GAP;
      end
      DONE: begin
        busy_d  = 1'b1;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pat_q   <= '0;
      sh_q    <= '0;
      bit_q   <= '0;
      rep_q   <= '0;
      gap_q   <= '0;
      busy_q  <= 1'b0;
      data_q  <= 1'b0;
      valid_q <= 1'b0;
      fs_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      rep_q   <= rep_d;
      gap_q   <= gap_d;
      busy_q  <= busy_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fs_q    <= fs_d;
      done_q  <= done_d;
    end
  end
  assign busy        = busy_q;
  assign data_out    = data_q;
  assign data_valid  = valid_q;
  assign frame_start = fs_q;
  assign done        = done_q;
endmodule

// File: tb/tb_sequence_generator.sv
// tb_sequence_generator: table vectors, corner sequences and random stimulus against a timeline model
module tb_sequence_generator;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] st, busy, dout, dv, fs, dn;
  logic [3:0] pat [2];
  logic [7:0] rc [2];
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sequence_generator #(.PAT_W(4), .CNT_W(8), .GAP_CYC(0)) u0 (
    .clk(clk), .rst(rst), .start(st[0]), .pattern(pat[0]), .repeat_cnt(rc[0]),
    .busy(busy[0]), .data_out(dout[0]), .data_valid(dv[0]), .frame_start(fs[0]), .done(dn[0]));
  sequence_generator #(.PAT_W(4), .CNT_W(8), .GAP_CYC(2)) u2 (
    .clk(clk), .rst(rst), .start(st[1]), .pattern(pat[1]), .repeat_cnt(rc[1]),
    .busy(busy[1]), .data_out(dout[1]), .data_valid(dv[1]), .frame_start(fs[1]), .done(dn[1]));

  // 1101 detector (in transmit order) listening to the back-to-back instance
  logic [3:0] hist;
  logic det;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hist <= '0;
      det  <= 1'b0;
    end else begin
      det <= dv[0] && {hist[2:0], dout[0]} == 4'b1101;
      if (dv[0]) hist <= {hist[2:0], dout[0]};
    end
  end

  // Model: on acceptance, the whole output timeline of the request is queued up front
  typedef struct packed {logic b, d, v, f, n;} out_t;
  out_t mq [2][$];
  out_t vis [2];

  task automatic model_edge(input int g);
    int r_n, gap;
    gap = g ? 2 : 0;
    if (rst) begin
      mq[g].delete();
      vis[g] = '0;
    end else begin
      if (st[g] && !vis[g].b && mq[g].size() == 0) begin
        r_n = rc[g] == 0 ? 1 : int'(rc[g]);
        mq[g].push_back('0);
        for (int r = 0; r < r_n; r++) begin
          for (int j = 0; j < (r > 0 ? gap : 0); j++) mq[g].push_back(out_t'{1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
          for (int i = 0; i < 4; i++) mq[g].push_back(out_t'{1'b1, pat[g][i], 1'b1, i == 0, 1'b0});
        end
        mq[g].push_back(out_t'{1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
      end
      vis[g] = mq[g].size() > 0 ? mq[g].pop_front() : '0;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", nm, $time, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    for (int g = 0; g < 2; g++) begin
      n_chk++;
      if (out_t'{busy[g], dout[g], dv[g], fs[g], dn[g]} !== vis[g]) begin
        n_err++;
        $display("FAIL model%0d t=%0t got=%b exp=%b", g, $time,
                 out_t'{busy[g], dout[g], dv[g], fs[g], dn[g]}, vis[g]);
      end
    end
  endtask

  typedef struct {
    string nm; int g; logic [3:0] p; logic [7:0] r; int poke;
    int len; int nb; logic [31:0] bits; logic [31:0] fsm; int done_at; logic [31:0] dm;
  } vec_t;
  vec_t tbl [9];

  task automatic apply(input vec_t v);
    int len, nb, done_at;
    logic [31:0] bits, fsm, dm;
    len = 0; nb = 0; done_at = -1; bits = '0; fsm = '0; dm = '0;
    st[v.g] = 1'b1; pat[v.g] = v.p; rc[v.g] = v.r;
    step();
    st[v.g] = 1'b0; pat[v.g] = 4'($urandom); rc[v.g] = 8'($urandom);
    for (int k = 1; k <= 1100; k++) begin
      step();
      st[v.g] = 1'b0;
      if (busy[v.g]) len++;
      if (dv[v.g]) begin
        if (nb < 32) bits[nb] = dout[v.g];
        nb++;
      end
      if (k < 32 && fs[v.g]) fsm[k] = 1'b1;
      if (k < 32 && det) dm[k] = 1'b1;
      if (dn[v.g]) done_at = k;
      if (k == v.poke) begin
        st[v.g] = 1'b1;
        pat[v.g] = 4'b1111;
      end
      if (!busy[v.g]) break;
    end
    chk({v.nm, " len"}, len, v.len);
    chk({v.nm, " nbits"}, nb, v.nb);
    chk({v.nm, " bits"}, bits, v.bits);
    chk({v.nm, " frame_start"}, fsm, v.fsm);
    chk({v.nm, " done_at"}, done_at, v.done_at);
    chk({v.nm, " detect"}, dm, v.dm);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{"single", 0, 4'b1011, 8'd1, -1, 5, 4, 32'hB, 32'h2, 5, 32'h20};
    tbl[1] = '{"rep3", 0, 4'b1011, 8'd3, -1, 13, 12, 32'hBBB, 32'h222, 13, 32'h2220};
    tbl[2] = '{"gap2", 1, 4'b0110, 8'd2, -1, 11, 8, 32'h66, 32'h82, 11, 32'h0};
    tbl[3] = '{"rep0_poke", 0, 4'b1011, 8'd0, 1, 5, 4, 32'hB, 32'h2, 5, 32'h20};
    tbl[4] = '{"poke_done", 0, 4'b1011, 8'd1, 5, 5, 4, 32'hB, 32'h2, 5, 32'h20};
    tbl[5] = '{"gap_0001", 1, 4'b0001, 8'd2, -1, 11, 8, 32'h11, 32'h82, 11, 32'h0};
    tbl[6] = '{"gap_rep3", 1, 4'b1000, 8'd3, 3, 17, 12, 32'h888, 32'h2082, 17, 32'h0};
    tbl[7] = '{"loop5", 0, 4'b1011, 8'd5, -1, 21, 20, 32'hBBBBB, 32'h22222, 21, 32'h222220};
    tbl[8] = '{"all_ones", 0, 4'b1011, 8'hFF, -1, 1021, 1020, 32'hBBBBBBBB, 32'h22222222, 1021, 32'h22222220};
    rst = 1'b1; st = '0;
    pat[0] = '0; pat[1] = '0; rc[0] = '0; rc[1] = '0;
    step();
    step();
    rst = 1'b0;
    step();
    for (int i = 0; i < 9; i++) apply(tbl[i]);
    // reset in the middle of a frame on both instances
    st = 2'b11; pat[0] = 4'b1011; pat[1] = 4'b1011; rc[0] = 8'd2; rc[1] = 8'd2;
    step();
    st = 2'b00;
    step();
    step();
    #3;
    rst = 1'b1;
    #1;
    for (int g = 0; g < 2; g++) begin
      mq[g].delete();
      vis[g] = '0;
    end
    chk("async busy", {busy, dv, dout, fs, dn}, 10'h0);
    step();
    rst = 1'b0;
    step();
    apply(tbl[0]);
    for (int c = 0; c < 600; c++) begin
      for (int g = 0; g < 2; g++) begin
        st[g] = $urandom_range(0, 3) == 0;
        pat[g] = 4'($urandom);
        rc[g] = $urandom_range(0, 9) == 0 ? 8'd0 : 8'($urandom_range(1, 3));
      end
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
